// File: rtl/sample_buf_pkg.sv
// Shared types for the sample capture buffer: the capture FSM state encoding.
package sample_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/sample_buf_ram.sv
// Simple dual-port sample storage: one write port, one registered read port.
// Array contents are never reset; only the read output register is.
module sample_buf_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the array before this edge's write lands (read-before-write).
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_sample_buffer.sv
// Circular sample capture buffer with stop-when-full or overwrite-oldest modes.
// Optional SAMPLE_BUF_STATS_EN adds a 32-bit total accepted-write counter port.
module param_sample_buffer
  import sample_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     mode_ovw,
  input  logic                     clear,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     frozen
`ifdef SAMPLE_BUF_STATS_EN
  ,
  output logic [31:0]              total_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  buf_state_e        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     old_ptr_q, old_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_zero_q, rd_zero_d;
  logic              wr_acc;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // A clear in the same cycle drops the write entirely.
  assign wr_acc = wr_valid && wr_ready && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = enable ? CAPTURE : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = CAPTURE;
        CAPTURE: begin
          if (wr_acc && !mode_ovw && count_q == CW'(DEPTH - 1)) state_d = FROZEN;
          else if (!enable)                                       state_d = IDLE;
        end
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ready = (state_q == CAPTURE) && (!full || mode_ovw);
    frozen   = (state_q == FROZEN);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    old_ptr_d = old_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (clear) begin
      wr_ptr_d  = '0;
      old_ptr_d = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
    end else if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full) begin
        old_ptr_d = old_ptr_q + 1'b1;
        ovf_d     = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Out-of-range check uses the pre-write count, matching the RAM's read-before-write.
  always_comb begin
    rd_valid_d = rd_req;
    rd_zero_d  = rd_zero_q;
    if (rd_req) rd_zero_d = ({1'b0, rd_idx} >= count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      old_ptr_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      old_ptr_q  <= old_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  assign rd_addr = old_ptr_q + rd_idx;

  sample_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_req),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_zero_q ? '0 : ram_rdata;
  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef SAMPLE_BUF_STATS_EN
  logic [31:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (clear)       total_d = '0;
    else if (wr_acc) total_d = total_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= total_d;
  end

  assign total_cnt = total_q;
`endif

endmodule

// File: tb/tb_param_sample_buffer.sv
// Self-checking bench for param_sample_buffer (DATA_W=8, DEPTH=16): queue model,
// read scoreboard, table-driven read vectors and hand-written corner sequences.
module tb_param_sample_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, mode_ovw = 1'b0, clear = 1'b0;
  logic       wr_valid = 1'b0, rd_req = 1'b0;
  logic [7:0] wr_data = '0;
  logic [3:0] rd_idx = '0;
  logic       wr_ready, rd_valid, full, empty, overflow, frozen;
  logic [7:0] rd_data;
  logic [4:0] count;
`ifdef SAMPLE_BUF_STATS_EN
  logic [31:0] total_cnt;
`endif

  always #5 clk = ~clk;

  param_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mode_ovw (mode_ovw),
    .clear    (clear),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .frozen   (frozen)
`ifdef SAMPLE_BUF_STATS_EN
    ,
    .total_cnt(total_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string      name;
    logic [7:0] data;
    int         due;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  typedef struct {
    string      name;
    logic [3:0] idx;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t vec[8];

  // Reference model: stored samples oldest-first, FSM state 0=IDLE 1=CAPTURE 2=FROZEN.
  logic [7:0] m_q[$];
  int         m_state = 0;
  bit         m_ovf   = 1'b0;
  int         m_total = 0;
  int         exp_override = -1;
  string      cur_name = "model_read";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_total = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit      mfull, rdy, acc;
    rd_exp_t e;
    mfull = (m_q.size() == DEPTH);
    rdy   = (m_state == 1) && (!mfull || mode_ovw);
    acc   = wr_valid && rdy && !clear;
    if (rd_req) begin
      e.name = cur_name;
      if (exp_override >= 0)          e.data = exp_override[7:0];
      else if (rd_idx < m_q.size())   e.data = m_q[rd_idx];
      else                            e.data = 8'h00;
      e.due = cyc + 1;
      exp_q.push_back(e);
    end
    if (clear) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_total = 0;
      m_state = enable ? 1 : 0;
    end else begin
      if (acc) begin
        if (mfull) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        m_q.push_back(wr_data);
        m_total++;
      end
      case (m_state)
        0: if (enable) m_state = 1;
        1: begin
          if (acc && !mode_ovw && m_q.size() == DEPTH) m_state = 2;
          else if (!enable)                            m_state = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    cyc++;
    #1;
  endtask

  // Read scoreboard: each request is due exactly one edge after it is sampled.
  rd_exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      chk({mon_e.name, ".rd_valid"}, rd_valid, 1'b1);
      if (rd_valid) chk({mon_e.name, ".rd_data"}, rd_data, mon_e.data);
    end else if (rd_valid) begin
      chk("unexpected_rd_valid", rd_valid, 1'b0);
    end
  end

  task automatic chk_status(input string tag);
    chk({tag, ".count"},    count,    m_q.size());
    chk({tag, ".full"},     full,     m_q.size() == DEPTH);
    chk({tag, ".empty"},    empty,    m_q.size() == 0);
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".frozen"},   frozen,   m_state == 2);
    chk({tag, ".wr_ready"}, wr_ready, (m_state == 1) && (m_q.size() < DEPTH || mode_ovw));
`ifdef SAMPLE_BUF_STATS_EN
    chk({tag, ".total_cnt"}, total_cnt, m_total);
`endif
  endtask

  task automatic wr_burst(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(start + i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [3:0] idx, input int ovr);
    rd_req       = 1'b1;
    rd_idx       = idx;
    cur_name     = name;
    exp_override = ovr;
    tick();
    rd_req       = 1'b0;
    exp_override = -1;
    cur_name     = "model_read";
  endtask

  task automatic run_vec(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      do_read(vec[i].name, vec[i].idx, int'(vec[i].exp));
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0] = '{"full_stop_idx0",  4'd0,  8'h00};
    vec[1] = '{"full_stop_idx15", 4'd15, 8'h0F};
    vec[2] = '{"ovw_idx0",        4'd0,  8'h04};
    vec[3] = '{"ovw_idx1",        4'd1,  8'h05};
    vec[4] = '{"ovw_idx7",        4'd7,  8'h0B};
    vec[5] = '{"ovw_idx15",       4'd15, 8'h13};
    vec[6] = '{"oob_idx5",        4'd5,  8'h00};
    vec[7] = '{"third_idx2",      4'd2,  8'hA3};

    // Reset state
    model_reset();
    tick();
    tick();
    chk("rst.rd_valid", rd_valid, 1'b0);
    chk("rst.rd_data",  rd_data,  8'h00);
    chk_status("rst");
    rst_n = 1'b1;

    // Stop-when-full: fill, freeze, reads still work
    enable   = 1'b1;
    mode_ovw = 1'b0;
    tick();
    wr_burst(8'h00, 16);
    chk("stop.full",     full,     1'b1);
    chk("stop.frozen",   frozen,   1'b1);
    chk("stop.wr_ready", wr_ready, 1'b0);
    wr_burst(8'hAA, 1);
    chk_status("stop_extra_write");
    run_vec(0, 1);
    enable = 1'b0;
    tick();
    chk("frozen_ignores_enable", frozen, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_status("clear_to_idle");

    // Overwrite mode: 20 writes into 16 entries
    enable   = 1'b1;
    mode_ovw = 1'b1;
    tick();
    wr_burst(8'h00, 20);
    chk("ovw.count",    count,    5'd16);
    chk("ovw.overflow", overflow, 1'b1);
`ifdef SAMPLE_BUF_STATS_EN
    chk("ovw.total_cnt", total_cnt, 32'd20);
`endif
    chk_status("ovw");
    run_vec(2, 5);

    // Read and overwriting write in the same cycle: read sees the old oldest entry
    rd_req   = 1'b1;
    rd_idx   = 4'd0;
    cur_name = "rbw_ovw_idx0";
    wr_valid = 1'b1;
    wr_data  = 8'h14;
    tick();
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    do_read("after_rbw_idx0", 4'd0, 8'h05);
    do_read("after_rbw_idx15", 4'd15, 8'h14);
    tick();

    // Clear on a full buffer with a same-cycle write
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    chk("clr.count",    count,    5'd0);
    chk("clr.empty",    empty,    1'b1);
    chk("clr.overflow", overflow, 1'b0);
    chk_status("clr");
    do_read("clr_idx0", 4'd0, -1);
    tick();

    // Three writes, out-of-range and in-range reads
    mode_ovw = 1'b0;
    wr_burst(8'hA1, 3);
    run_vec(6, 7);
    rd_req   = 1'b1;
    rd_idx   = 4'd3;
    cur_name = "rbw_oob_idx3";
    wr_valid = 1'b1;
    wr_data  = 8'hA4;
    tick();
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    do_read("after_rbw_idx3", 4'd3, 8'hA4);
    tick();

    // Asynchronous reset mid-capture with a read outstanding
    wr_burst(8'hB5, 3);
    chk("pre_rst.count", count, 5'd7);
    do_read("pre_rst_idx5", 4'd5, 8'hB6);
    @(negedge clk);
    #1;
    rd_req = 1'b1;
    rd_idx = 4'd1;
    rst_n  = 1'b0;
    #1;
    chk("async_rst.rd_valid", rd_valid, 1'b0);
    chk("async_rst.rd_data",  rd_data,  8'h00);
    chk("async_rst.count",    count,    5'd0);
    chk("async_rst.frozen",   frozen,   1'b0);
    chk("async_rst.wr_ready", wr_ready, 1'b0);
    model_reset();
    chk_status("async_rst");
    tick();
    rd_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst.rd_valid", rd_valid, 1'b0);
    chk_status("post_rst");

    // CAPTURE -> IDLE on enable low; writes then refused
    enable = 1'b0;
    tick();
    chk("disable.wr_ready", wr_ready, 1'b0);
    wr_burst(8'h77, 2);
    chk_status("disable");

    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
